// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit_if
// Brief    : ROM address/data bus and decoder valid/ready/jump handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              jump_valid;
  logic [ADDR_W-1:0] jump_target;

  modport master (
    output rom_address,
    input  rom_data,
    output instr,
    output instr_valid,
    input  instr_ready,
    input  jump_valid,
    input  jump_target
  );

  modport slave (
    input  rom_address,
    output rom_data,
    input  instr,
    input  instr_valid,
    output instr_ready,
    output jump_valid,
    output jump_target
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Program counter and fetch sequencer with run/step and jump redirect.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire                 clk,
  input  wire                 rst_n,
  input  wire                 run,
  input  wire                 step,
  pc_fetch_unit_if.master     bus,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted,
  output logic [15:0]         retire_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] w_instr_nxt;
  logic              r_instr_valid;
  logic              w_instr_valid_nxt;
  logic [15:0]       r_retire;
  logic [15:0]       w_retire_nxt;
  logic              w_handshake;

  assign w_handshake = (r_state == ST_ISSUE) && bus.instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_retire      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_retire      <= w_retire_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_instr_nxt       = r_instr;
    w_instr_valid_nxt = r_instr_valid;
    w_retire_nxt      = r_retire;
    case (r_state)
      ST_IDLE: begin
        w_instr_valid_nxt = 1'b0;
        if (run || step) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_instr_nxt       = bus.rom_data;
        w_instr_valid_nxt = 1'b1;
        w_pc_nxt          = r_pc + ADDR_W'(1);
        w_state_nxt       = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_handshake) begin
          w_instr_valid_nxt = 1'b0;
          if (r_retire != 16'hFFFF) begin
            w_retire_nxt = r_retire + 16'd1;
          end
          // A redirect only counts when it rides on the accepting cycle.
          if (bus.jump_valid) begin
            w_pc_nxt = bus.jump_target;
          end
          w_state_nxt = run ? ST_FETCH : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt       = ST_IDLE;
        w_instr_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.rom_address = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign pc              = r_pc;
  assign halted          = (r_state == ST_IDLE);
  assign retire_count    = r_retire;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Directed self-checking bench for pc_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] retire_count;
  logic [7:0]  rom [0:255];
  logic [7:0]  step_exp [0:2];
  int          n_checks;
  int          n_errors;

  pc_fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  assign bus.rom_data = rom[bus.rom_address];

  pc_fetch_unit #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .step         (step),
    .bus          (bus),
    .pc           (pc),
    .halted       (halted),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[1] = 8'hB1; rom[2] = 8'h0A; rom[3] = 8'h82; rom[4] = 8'h44; rom[5] = 8'h9E;
    rom[255] = 8'h5A;
    step_exp[0] = 8'h00; step_exp[1] = 8'hB1; step_exp[2] = 8'h0A;

    rst_n = 1'b0; run = 1'b1; step = 1'b0;
    bus.instr_ready = 1'b1; bus.jump_valid = 1'b0; bus.jump_target = 8'h00;

    // Reset held with run=1
    nc(2);
    check("rst_pc",      pc,              8'h00);
    check("rst_romaddr", bus.rom_address, 8'h00);
    check("rst_instr",   bus.instr,       8'h00);
    check("rst_valid",   bus.instr_valid, 1'b0);
    check("rst_halted",  halted,          1'b1);
    check("rst_retire",  retire_count,    16'd0);

    rst_n = 1'b1;
    nc(1);
    check("edge1_valid",  bus.instr_valid, 1'b0);
    check("edge1_halted", halted,          1'b0);
    nc(1);
    check("edge2_valid", bus.instr_valid, 1'b1);
    check("i0_instr",    bus.instr,       8'h00);
    check("i0_pc",       pc,              8'h01);

    // Free run, ready held high
    nc(1);
    check("hs0_valid",  bus.instr_valid, 1'b0);
    check("hs0_retire", retire_count,    16'd1);
    nc(1);
    check("i1_instr", bus.instr, 8'hB1);
    check("i1_pc",    pc,        8'h02);
    nc(1);
    check("hs1_retire", retire_count, 16'd2);
    nc(1);
    check("i2_instr", bus.instr, 8'h0A);
    check("i2_pc",    pc,        8'h03);

    // Backpressure with a jump that must be ignored
    bus.instr_ready = 1'b0; bus.jump_valid = 1'b1; bus.jump_target = 8'h40;
    for (int k = 0; k < 5; k++) begin
      nc(1);
      check("bp_instr", bus.instr,       8'h0A);
      check("bp_valid", bus.instr_valid, 1'b1);
      check("bp_pc",    pc,              8'h03);
    end
    bus.instr_ready = 1'b1; bus.jump_valid = 1'b0;
    nc(1);
    check("bp_hs_valid",  bus.instr_valid, 1'b0);
    check("bp_hs_retire", retire_count,    16'd3);
    check("bp_hs_pc",     pc,              8'h03);
    nc(1);
    check("i3_instr", bus.instr, 8'h82);
    check("i3_pc",    pc,        8'h04);
    nc(2);
    check("i4_instr",  bus.instr,    8'h44);
    check("i4_pc",     pc,           8'h05);
    check("i4_retire", retire_count, 16'd4);
    nc(2);
    check("i5_instr", bus.instr, 8'h9E);
    check("i5_pc",    pc,        8'h06);

    // Jump on the handshake of 0x9E
    bus.jump_valid = 1'b1; bus.jump_target = 8'h00;
    nc(1);
    check("jmp_retire", retire_count,    16'd6);
    check("jmp_pc",     pc,              8'h00);
    check("jmp_valid",  bus.instr_valid, 1'b0);
    bus.jump_valid = 1'b0;
    nc(1);
    check("jmp_instr", bus.instr,       8'h00);
    check("jmp_pc2",   pc,              8'h01);
    check("jmp_valid2", bus.instr_valid, 1'b1);

    // Drop run; final handshake rewinds pc to 0 and goes idle
    run = 1'b0; bus.jump_valid = 1'b1; bus.jump_target = 8'h00;
    nc(1);
    check("stop_halted", halted,          1'b1);
    check("stop_pc",     pc,              8'h00);
    check("stop_valid",  bus.instr_valid, 1'b0);
    check("stop_retire", retire_count,    16'd7);
    bus.jump_valid = 1'b0;

    // Three step pulses six cycles apart
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      nc(1);
      step = 1'b0;
      check("step_fetch_halted", halted, 1'b0);
      nc(1);
      check("step_instr", bus.instr,       step_exp[k]);
      check("step_valid", bus.instr_valid, 1'b1);
      check("step_pc",    pc,              k + 1);
      nc(4);
      check("step_idle_halted", halted,          1'b1);
      check("step_idle_valid",  bus.instr_valid, 1'b0);
      check("step_retire",      retire_count,    8 + k);
    end

    // Step pulse during ISSUE must not trigger a second fetch
    bus.instr_ready = 1'b0; step = 1'b1;
    nc(1);
    step = 1'b0;
    nc(1);
    check("sti_instr", bus.instr, 8'h82);
    check("sti_pc",    pc,        8'h04);
    step = 1'b1;
    nc(1);
    step = 1'b0;
    check("sti_hold_valid",  bus.instr_valid, 1'b1);
    check("sti_hold_halted", halted,          1'b0);
    bus.instr_ready = 1'b1;
    nc(1);
    check("sti_hs_halted", halted,       1'b1);
    check("sti_hs_retire", retire_count, 16'd11);
    nc(2);
    check("sti_idle_halted", halted,          1'b1);
    check("sti_idle_pc",     pc,              8'h04);
    check("sti_idle_valid",  bus.instr_valid, 1'b0);

    // Jump to 0xFF, then run across the wrap
    step = 1'b1;
    nc(1);
    step = 1'b0;
    nc(1);
    check("wr_instr", bus.instr, 8'h44);
    check("wr_pc",    pc,        8'h05);
    bus.jump_valid = 1'b1; bus.jump_target = 8'hFF;
    nc(1);
    check("wr_jmp_halted", halted,       1'b1);
    check("wr_jmp_pc",     pc,           8'hFF);
    check("wr_jmp_retire", retire_count, 16'd12);
    bus.jump_valid = 1'b0; run = 1'b1;
    nc(2);
    check("wr_ff_instr", bus.instr, 8'h5A);
    check("wr_ff_pc",    pc,        8'h00);
    nc(2);
    check("wr_00_instr",  bus.instr,       8'h00);
    check("wr_00_pc",     pc,              8'h01);
    check("wr_00_valid",  bus.instr_valid, 1'b1);
    check("wr_00_retire", retire_count,    16'd13);

    // Asynchronous reset while an instruction is pending
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",   bus.instr_valid, 1'b0);
    check("arst_pc",      pc,              8'h00);
    check("arst_romaddr", bus.rom_address, 8'h00);
    check("arst_instr",   bus.instr,       8'h00);
    check("arst_halted",  halted,          1'b1);
    check("arst_retire",  retire_count,    16'd0);
    run = 1'b0;
    nc(1);
    rst_n = 1'b1;
    nc(3);
    check("post_halted", halted,          1'b1);
    check("post_valid",  bus.instr_valid, 1'b0);
    check("post_pc",     pc,              8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
